// File: rtl/sr_cmd_pkg.sv
// Shared types for the SR command generator: FSM states, command kinds
// and the default debounce length.
package sr_cmd_pkg;

  localparam int DEB_CYCLES_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    CHECK = 2'd2
  } state_t;

  typedef enum logic {
    CMD_SET = 1'b0,
    CMD_CLR = 1'b1
  } cmd_t;

endpackage

// File: rtl/sr_debounce.sv
// Single-input debouncer: one sync flop, a run-length counter and the
// debounced level. rise_o is high in the cycle whose closing edge flips the
// debounced value from 0 to 1, so a consumer can latch it on that same edge.
module sr_debounce
  import sr_cmd_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int CNT_W      = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic rise_o
);

  logic             sync_q;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive disagreements; flip the debounced level when the run
  // would reach DEB_CYCLES.
  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    if (sync_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
      cnt_d = '0;
      deb_d = ~deb_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign rise_o = deb_d & ~deb_q;

  // Sync flop, debounced level and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 1'b0;
      deb_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= raw_i;
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/sr_cmd_gen.sv
// SR flip-flop command generator: debounces set/clear requests, turns each
// debounced rising edge into a single s/r pulse (never both at once) and,
// when SR_FB_CHECK_EN is defined, checks q feedback after each command and
// raises a sticky err flag on mismatch. Without the macro the CHECK state
// is skipped, err is 0 and q_fb is ignored.
module sr_cmd_gen
  import sr_cmd_pkg::*;
#(
  parameter int DEB_CYCLES   = DEB_CYCLES_DEF,
  parameter int CNT_W        = 3,
  parameter bit CLR_PRIORITY = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic set_in,
  input  logic clr_in,
  input  logic q_fb,
  output logic s_out,
  output logic r_out,
  output logic busy,
  output logic err
);

  logic   rise_s, rise_r;
  state_t state_q, state_d;
  logic   pend_s_q, pend_s_d;
  logic   pend_r_q, pend_r_d;
  logic   s_q, s_d;
  logic   r_q, r_d;
  cmd_t   cmd;
`ifdef SR_FB_CHECK_EN
  logic   exp_q, exp_d;
  logic   err_q, err_d;
`endif

  sr_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_set (
    .clk    (clk),
    .rst    (rst),
    .raw_i  (set_in),
    .rise_o (rise_s)
  );

  sr_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_clr (
    .clk    (clk),
    .rst    (rst),
    .raw_i  (clr_in),
    .rise_o (rise_r)
  );

  // Arbitration, FSM next state, pulse outputs and pending bookkeeping.
  always_comb begin
    state_d  = state_q;
    pend_s_d = pend_s_q;
    pend_r_d = pend_r_q;
    s_d      = 1'b0;
    r_d      = 1'b0;
    cmd      = CMD_SET;
`ifdef SR_FB_CHECK_EN
    exp_d    = exp_q;
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (pend_s_q || pend_r_q) begin
          cmd      = (pend_r_q && (CLR_PRIORITY || !pend_s_q)) ? CMD_CLR : CMD_SET;
          s_d      = (cmd == CMD_SET);
          r_d      = (cmd == CMD_CLR);
          // Winner is consumed; a losing simultaneous request is dropped.
          pend_s_d = 1'b0;
          pend_r_d = 1'b0;
          state_d  = PULSE;
`ifdef SR_FB_CHECK_EN
          exp_d    = (cmd == CMD_SET);
`endif
        end
      end
      PULSE: begin
`ifdef SR_FB_CHECK_EN
        state_d = CHECK;
`else
        state_d = IDLE;
`endif
      end
      CHECK: begin
`ifdef SR_FB_CHECK_EN
        if (q_fb != exp_q) err_d = 1'b1;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // New debounced edges are latched even while busy; they merge if pending.
    pend_s_d = pend_s_d | rise_s;
    pend_r_d = pend_r_d | rise_r;
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pend_s_q <= 1'b0;
      pend_r_q <= 1'b0;
      s_q      <= 1'b0;
      r_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_s_q <= pend_s_d;
      pend_r_q <= pend_r_d;
      s_q      <= s_d;
      r_q      <= r_d;
    end
  end

`ifdef SR_FB_CHECK_EN
  // Expected q and the sticky mismatch flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      exp_q <= exp_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  logic unused_q_fb;
  assign unused_q_fb = q_fb;
  assign err         = 1'b0;
`endif

  assign s_out = s_q;
  assign r_out = r_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Bench for sr_cmd_gen: two instances (clear-priority and set-priority) share
// the same stimulus; a behavioural model predicts each pulse and its cycle,
// and a negedge monitor pops and compares.
module tb_sr_cmd_gen;

  localparam int DEB = 4;
`ifdef SR_FB_CHECK_EN
  localparam int SPACING = 3;
  localparam bit FB      = 1'b1;
`else
  localparam int SPACING = 2;
  localparam bit FB      = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, set_in, clr_in, q_fb;
  logic [1:0] s_out, r_out, busy, err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct packed {
    int cyc;
    bit is_clr;
  } exp_t;

  exp_t sbq0[$];
  exp_t sbq1[$];

  // Model state: raw-sample history per input, debounced levels, and per
  // instance pending flags / last dispatch cycle / expected q / err.
  bit [7:0] hs, hr;
  int       nvalid;
  bit       deb_s, deb_r;
  bit       pend_s[2], pend_r[2];
  int       last_p[2];
  bit       exp_q[2];
  bit       err_m[2];

  sr_cmd_gen #(.DEB_CYCLES(DEB), .CNT_W(3), .CLR_PRIORITY(1'b1)) u_clr (
    .clk(clk), .rst(rst), .set_in(set_in), .clr_in(clr_in), .q_fb(q_fb),
    .s_out(s_out[0]), .r_out(r_out[0]), .busy(busy[0]), .err(err[0])
  );

  sr_cmd_gen #(.DEB_CYCLES(DEB), .CNT_W(3), .CLR_PRIORITY(1'b0)) u_set (
    .clk(clk), .rst(rst), .set_in(set_in), .clr_in(clr_in), .q_fb(q_fb),
    .s_out(s_out[1]), .r_out(r_out[1]), .busy(busy[1]), .err(err[1])
  );

  always #5 clk = ~clk;

  // True when the last DEB raw samples all disagree with level d.
  function automatic bit window_differs(input bit [7:0] h, input int nv, input bit d);
    bit [7:0] mask;
    mask = 8'((1 << DEB) - 1);
    return (nv >= DEB) && ((h & mask) == (d ? 8'h00 : mask));
  endfunction

  initial begin
    hs = '0; hr = '0; nvalid = 0; deb_s = 0; deb_r = 0;
    for (int k = 0; k < 2; k++) begin
      pend_s[k] = 0; pend_r[k] = 0; last_p[k] = -100; exp_q[k] = 0; err_m[k] = 0;
    end
  end

  // Reference model, advanced once per rising edge.
  always @(posedge clk) begin
    bit fs, fr, rs, rr, clr;
    cyc++;
    if (rst) begin
      hs = '0; hr = '0; nvalid = 0; deb_s = 0; deb_r = 0;
      for (int k = 0; k < 2; k++) begin
        pend_s[k] = 0; pend_r[k] = 0; last_p[k] = -100; err_m[k] = 0;
      end
    end else begin
      fs = window_differs(hs, nvalid, deb_s);
      fr = window_differs(hr, nvalid, deb_r);
      rs = fs && !deb_s;
      rr = fr && !deb_r;
      if (fs) deb_s = !deb_s;
      if (fr) deb_r = !deb_r;
      hs = {hs[6:0], set_in};
      hr = {hr[6:0], clr_in};
      if (nvalid < 8) nvalid++;
      for (int k = 0; k < 2; k++) begin
        if (FB && (last_p[k] + 2 == cyc) && (q_fb != exp_q[k])) err_m[k] = 1;
        if ((cyc >= last_p[k] + SPACING) && (pend_s[k] || pend_r[k])) begin
          clr = pend_r[k] && ((k == 0) || !pend_s[k]);
          if (k == 0) sbq0.push_back('{cyc: cyc, is_clr: clr});
          else        sbq1.push_back('{cyc: cyc, is_clr: clr});
          exp_q[k]  = !clr;
          last_p[k] = cyc;
          pend_s[k] = 0;
          pend_r[k] = 0;
        end
        pend_s[k] = pend_s[k] | rs;
        pend_r[k] = pend_r[k] | rr;
      end
    end
  end

  task automatic check_inst(input int k);
    exp_t front;
    bit   have;
    bit   bexp;
    have = 0;
    if (k == 0 && sbq0.size() > 0 && sbq0[0].cyc == cyc) begin front = sbq0.pop_front(); have = 1; end
    if (k == 1 && sbq1.size() > 0 && sbq1[0].cyc == cyc) begin front = sbq1.pop_front(); have = 1; end
    total++;
    if (s_out[k] || r_out[k]) begin
      if (!have || (front.is_clr != r_out[k]) || (s_out[k] == r_out[k])) begin
        bad++;
        $display("FAIL pulse inst%0d cyc=%0d got s=%0b r=%0b expected_pulse=%0b expected_clr=%0b",
                 k, cyc, s_out[k], r_out[k], have, have ? front.is_clr : 1'b0);
      end
    end else if (have) begin
      bad++;
      $display("FAIL missing_pulse inst%0d cyc=%0d got s=0 r=0 expected_clr=%0b", k, cyc, front.is_clr);
    end
    bexp = (cyc >= last_p[k]) && (cyc - last_p[k] < SPACING - 1);
    total++;
    if (busy[k] !== bexp) begin
      bad++;
      $display("FAIL busy inst%0d cyc=%0d got=%0b expected=%0b", k, cyc, busy[k], bexp);
    end
    total++;
    if (err[k] !== err_m[k]) begin
      bad++;
      $display("FAIL err inst%0d cyc=%0d got=%0b expected=%0b", k, cyc, err[k], err_m[k]);
    end
    total++;
    if ((s_out[k] & r_out[k]) !== 1'b0) begin
      bad++;
      $display("FAIL s_and_r inst%0d cyc=%0d got=%0b expected=0", k, cyc, s_out[k] & r_out[k]);
    end
  endtask

  // Monitor: compare every cycle once the first reset has been applied.
  always @(negedge clk) begin
    if (cyc >= 2) begin
      check_inst(0);
      check_inst(1);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int  found;
    bit  wrong;
    rst = 1; set_in = 0; clr_in = 0; q_fb = 0;
    step(3);
    rst = 0;
    step(2);

    // Held set with correct feedback.
    set_in = 1; q_fb = 1;
    step(12);
    set_in = 0;
    step(8);

    // Short glitches must not produce pulses.
    repeat (5) begin
      set_in = 1; step(3);
      set_in = 0; step(3);
    end

    // Simultaneous set and clear: instances disagree on the winner.
    set_in = 1; clr_in = 1;
    step(10);
    set_in = 0; clr_in = 0;
    step(10);

    // Clear with q_fb stuck at 1, then further commands; err stays sticky.
    rst = 1; step(1); rst = 0; step(2);
    q_fb = 1;
    clr_in = 1; step(10); clr_in = 0; step(6);
    repeat (3) begin
      set_in = 1; step(8); set_in = 0; step(6);
    end
    rst = 1; step(1); rst = 0; step(3);

    // Clear edge arriving while a set command is in flight.
    set_in = 1; step(1); clr_in = 1;
    step(12);
    set_in = 0; clr_in = 0;
    step(10);

    // Reset asserted during PULSE aborts the command.
    set_in = 1;
    found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      step(1);
      if (last_p[0] == cyc) found = 1;
    end
    total++;
    if (found == 0) begin
      bad++;
      $display("FAIL abort_wait got=no_dispatch expected=dispatch_within_60");
    end
    rst = 1; step(1); rst = 0;
    set_in = 0;
    step(12);

    // Randomized segments with bouncing inputs, noisy feedback and resets.
    repeat (150) begin
      int n;
      n      = $urandom_range(1, 12);
      set_in = 1'($urandom);
      clr_in = 1'($urandom);
      wrong  = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 24) == 0) rst = 1;
      repeat (n) begin
        q_fb = exp_q[0] ^ wrong;
        step(1);
        rst = 0;
      end
    end
    set_in = 0; clr_in = 0;
    step(20);

    total++;
    if (sbq0.size() != 0 || sbq1.size() != 0) begin
      bad++;
      $display("FAIL leftover got=%0d/%0d expected=0/0", sbq0.size(), sbq1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
